e203_rst_seq_ctrl: RTL and testbench

E203_RST_SEQ_CTRL -- requirements
Module: e203_rst_seq_ctrl

---
 rtl/e203_rst_seq_pkg.sv | 30 +++
 rtl/e203_rst_seq_ctrl_if.sv | 25 ++
 rtl/e203_rst_seq_sync.sv | 27 ++
 rtl/e203_rst_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_e203_rst_seq_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/e203_rst_seq_pkg.sv
// Shared encodings and default timing for the reset sequencer.
// Latency: none (constants only); backpressure: not applicable.
package e203_rst_seq_pkg;

  localparam int LOCK_STABLE_CYCLES_DEF = 16;
  localparam int CORE_DLY_CYCLES_DEF    = 8;
  localparam int DEBOUNCE_CYCLES_DEF    = 4;

  localparam int STATE_W = 3;
  localparam int CAUSE_W = 3;

  localparam logic [STATE_W-1:0] ST_HOLD      = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_SYS_UP    = 3'd3;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_POR       = 3'd0,
    CAUSE_LOCK_LOSS = 3'd1,
    CAUSE_EXT       = 3'd2,
    CAUSE_WDT       = 3'd3,
    CAUSE_SW        = 3'd4
  } rst_cause_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/e203_rst_seq_ctrl_if.sv
// Request inputs and reset/status outputs of the reset sequencer.
// Latency: wiring only; backpressure: none, all signals are level or pulse.
interface e203_rst_seq_ctrl_if;
  import e203_rst_seq_pkg::*;

  logic               pll_lock;
  logic               ext_rst_n;
  logic               wdt_rst_req;
  logic               sw_rst_req;
  logic               sys_rst_n;
  logic               core_rst_n;
  logic [CAUSE_W-1:0] rst_cause;
  logic [STATE_W-1:0] seq_state;

  modport master (
    output pll_lock, ext_rst_n, wdt_rst_req, sw_rst_req,
    input  sys_rst_n, core_rst_n, rst_cause, seq_state
  );

  modport slave (
    input  pll_lock, ext_rst_n, wdt_rst_req, sw_rst_req,
    output sys_rst_n, core_rst_n, rst_cause, seq_state
  );

endinterface

// File: rtl/e203_rst_seq_sync.sv
// Two-flop synchronizer with a selectable reset value.
// Latency: 2 clk; backpressure: none.
module e203_rst_seq_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/e203_rst_seq_ctrl.sv
// Power/clock reset sequencer: PLL-lock qualification, staged sys/core release, cause capture.
// Latency: outputs follow the state register by 0 cycles; backpressure: none.
module e203_rst_seq_ctrl
  import e203_rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int CORE_DLY_CYCLES    = CORE_DLY_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_rst_seq_ctrl_if.slave   bus
);

  localparam int CNT_MAX = max2(LOCK_STABLE_CYCLES, CORE_DLY_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  logic lock_sync;
  logic ext_sync;

  e203_rst_seq_sync #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pll_lock),
    .q_o   (lock_sync)
  );

  e203_rst_seq_sync #(.RST_VAL(1'b1)) u_ext_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.ext_rst_n),
    .q_o   (ext_sync)
  );

  // Debounce counter saturates so a long-held pad keeps the event asserted.
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            ext_evt;

  always_comb begin
    db_cnt_d = db_cnt_q;
    if (ext_sync) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES)) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign ext_evt = !ext_sync && (db_cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1));

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               core_rst_n_q, core_rst_n_d;

  logic       in_run;
  logic       lock_loss;
  logic       wdt_evt;
  logic       sw_evt;
  logic       up_evt;
  rst_cause_e up_cause;

  assign in_run    = (state_q == ST_RUN);
  assign lock_loss = !lock_sync;
  assign wdt_evt   = bus.wdt_rst_req && in_run;
  assign sw_evt    = bus.sw_rst_req && in_run;
  assign up_evt    = lock_loss || ext_evt || wdt_evt || sw_evt;

  always_comb begin
    up_cause = CAUSE_SW;
    if (lock_loss) begin
      up_cause = CAUSE_LOCK_LOSS;
    end else if (ext_evt) begin
      up_cause = CAUSE_EXT;
    end else if (wdt_evt) begin
      up_cause = CAUSE_WDT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_HOLD: begin
        cnt_d = '0;
        if (!ext_evt) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        // A lock glitch before release is not a reset event: just recount.
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (ext_evt) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = CAUSE_EXT;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_SYS_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SYS_UP, ST_RUN: begin
        if (up_evt) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = up_cause;
        end else if (state_q == ST_SYS_UP) begin
          if (cnt_q == CNT_W'(CORE_DLY_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset outputs are decoded from the next state so they switch on the transition edge.
  assign sys_rst_n_d  = (state_d == ST_SYS_UP) || (state_d == ST_RUN);
  assign core_rst_n_d = (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      cause_q      <= CAUSE_POR;
      db_cnt_q     <= '0;
      sys_rst_n_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      db_cnt_q     <= db_cnt_d;
      sys_rst_n_q  <= sys_rst_n_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.rst_cause  = cause_q;
  assign bus.seq_state  = state_q;

endmodule

// File: tb/tb_e203_rst_seq_ctrl.sv
// Directed plus randomized bench for e203_rst_seq_ctrl against an event/elapsed-time model.
module tb_e203_rst_seq_ctrl;

  localparam int LOCK_N = 16;
  localparam int CORE_N = 8;
  localparam int DEB_N  = 4;

  localparam int P_HOLD   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_SYSUP  = 3;
  localparam int P_RUN    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  e203_rst_seq_ctrl_if bus ();

  e203_rst_seq_ctrl #(
    .LOCK_STABLE_CYCLES (LOCK_N),
    .CORE_DLY_CYCLES    (CORE_N),
    .DEBOUNCE_CYCLES    (DEB_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // Reference model: phase plus the edge at which it was entered.
  bit m_lock[$];
  bit m_ext[$];
  int m_phase, m_since, m_cyc, m_last_hi, m_cause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_lock    = {1'b0, 1'b0};
    m_ext     = {1'b1, 1'b1};
    m_phase   = P_HOLD;
    m_cyc     = 0;
    m_since   = 0;
    m_last_hi = 0;
    m_cause   = 0;
  endtask

  task automatic go(input int p);
    m_phase = p;
    m_since = m_cyc;
  endtask

  task automatic model_step();
    bit lk, ex, ext_ev;
    int c, elapsed;
    m_cyc++;
    lk = m_lock.pop_front();
    m_lock.push_back(bus.pll_lock);
    ex = m_ext.pop_front();
    m_ext.push_back(bus.ext_rst_n);
    if (ex) m_last_hi = m_cyc;
    ext_ev  = !ex && ((m_cyc - m_last_hi) >= DEB_N);
    elapsed = m_cyc - m_since;
    case (m_phase)
      P_HOLD:   if (!ext_ev) go(P_WAIT);
      P_WAIT:   if (lk) go(P_STABLE);
      P_STABLE: begin
        if (!lk) go(P_WAIT);
        else if (ext_ev) begin m_cause = 2; go(P_HOLD); end
        else if (elapsed >= LOCK_N) go(P_SYSUP);
      end
      default: begin
        c = -1;
        if (!lk) c = 1;
        else if (ext_ev) c = 2;
        else if (m_phase == P_RUN && bus.wdt_rst_req) c = 3;
        else if (m_phase == P_RUN && bus.sw_rst_req) c = 4;
        if (c >= 0) begin
          m_cause = c;
          go(P_HOLD);
        end else if (m_phase == P_SYSUP && elapsed >= CORE_N) begin
          go(P_RUN);
        end
      end
    endcase
  endtask

  function automatic logic [7:0] model_out();
    logic s, k;
    s = (m_phase == P_SYSUP) || (m_phase == P_RUN);
    k = (m_phase == P_RUN);
    return {s, k, m_cause[2:0], m_phase[2:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    edge_n++;
    #1;
    chk("cycle", {bus.sys_rst_n, bus.core_rst_n, bus.rst_cause, bus.seq_state}, model_out());
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    bus.wdt_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    #1;
    model_reset();
    chk("async_rst", {bus.sys_rst_n, bus.core_rst_n, bus.rst_cause, bus.seq_state}, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // Clean power-on sequence with a software request landing in SYS_UP.
  task automatic por_sequence();
    for (int i = 1; i <= 30; i++) begin
      bus.sw_rst_req = (i == 22);
      cyc();
      bus.sw_rst_req = 1'b0;
      if (i == 18) chk("sys_before_19", bus.sys_rst_n, 1'b0);
      if (i == 19) chk("sys_at_19", {bus.sys_rst_n, bus.core_rst_n}, 2'b10);
      if (i == 26) chk("core_before_27", bus.core_rst_n, 1'b0);
      if (i == 27) chk("core_at_27", {bus.core_rst_n, bus.rst_cause}, {1'b1, 3'd0});
    end
  endtask

  initial begin
    bus.pll_lock    = 1'b1;
    bus.ext_rst_n   = 1'b1;
    bus.wdt_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    model_reset();
    #3;
    chk("por_state", {bus.sys_rst_n, bus.core_rst_n, bus.rst_cause, bus.seq_state}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    por_sequence();

    // External pad: 3 low cycles filtered, 4 low cycles reset.
    bus.ext_rst_n = 1'b0;
    repeat (3) cyc();
    bus.ext_rst_n = 1'b1;
    repeat (6) cyc();
    chk("ext3_ignored", {bus.sys_rst_n, bus.core_rst_n}, 2'b11);
    bus.ext_rst_n = 1'b0;
    repeat (4) cyc();
    bus.ext_rst_n = 1'b1;
    repeat (4) cyc();
    chk("ext4_reset", {bus.sys_rst_n, bus.core_rst_n, bus.rst_cause}, {2'b00, 3'd2});
    repeat (40) cyc();
    chk("ext_reseq", bus.core_rst_n, 1'b1);

    // Watchdog and software together: watchdog wins.
    bus.wdt_rst_req = 1'b1;
    bus.sw_rst_req  = 1'b1;
    cyc();
    bus.wdt_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    cyc();
    chk("wdt_over_sw", {bus.sys_rst_n, bus.rst_cause}, {1'b0, 3'd3});
    repeat (40) cyc();
    chk("wdt_reseq", bus.core_rst_n, 1'b1);

    // Lock loss coincident (post-sync) with software request.
    bus.pll_lock = 1'b0;
    repeat (2) cyc();
    bus.sw_rst_req = 1'b1;
    cyc();
    bus.sw_rst_req = 1'b0;
    chk("lockloss_cause", {bus.rst_cause, bus.seq_state}, {3'd1, 3'd0});
    cyc();
    chk("lockloss_wait", bus.seq_state, 3'd1);
    repeat (4) cyc();
    chk("lockloss_stay", {bus.sys_rst_n, bus.seq_state}, {1'b0, 3'd1});
    bus.pll_lock = 1'b1;
    repeat (40) cyc();
    chk("lock_reseq", {bus.core_rst_n, bus.rst_cause}, {1'b1, 3'd1});

    // Async reset while in SYS_UP with a non-POR cause latched.
    bus.wdt_rst_req = 1'b1;
    cyc();
    bus.wdt_rst_req = 1'b0;
    for (int i = 0; i < 100 && m_phase != P_SYSUP; i++) cyc();
    chk("reach_sysup", bus.seq_state, 3'd3);
    cyc();
    do_reset();
    por_sequence();

    // Single-cycle lock glitch during STABLE forces a full recount.
    do_reset();
    for (int i = 1; i <= 34; i++) begin
      bus.pll_lock = (i != 13);
      cyc();
      if (i == 15) chk("glitch_wait", bus.seq_state, 3'd1);
      if (i == 16) chk("glitch_stable", bus.seq_state, 3'd2);
      if (i == 19) chk("glitch_sys_low19", bus.sys_rst_n, 1'b0);
      if (i == 31) chk("glitch_sys_low31", bus.sys_rst_n, 1'b0);
      if (i == 32) chk("glitch_sys_up32", bus.sys_rst_n, 1'b1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if (bus.pll_lock) bus.pll_lock = ($urandom_range(0, 79) != 0);
      else              bus.pll_lock = ($urandom_range(0, 2) == 0);
      if (bus.ext_rst_n) bus.ext_rst_n = ($urandom_range(0, 24) != 0);
      else               bus.ext_rst_n = ($urandom_range(0, 3) == 0);
      bus.wdt_rst_req = ($urandom_range(0, 59) == 0);
      bus.sw_rst_req  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
